// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T1..T6 ring plus opcode decode into the 12-bit control word.
// Optional build macro SAP1_VAR_CYCLE_EN shortens LDA/OUT/undefined instructions.
module sap1_control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        halted
);

    // Control word bit positions, MSB first: {Cp,Ep,Lm,Er,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam logic [11:0] CP = 12'h800;
    localparam logic [11:0] EP = 12'h400;
    localparam logic [11:0] LM = 12'h200;
    localparam logic [11:0] ER = 12'h100;
    localparam logic [11:0] LI = 12'h080;
    localparam logic [11:0] EI = 12'h040;
    localparam logic [11:0] LA = 12'h020;
    localparam logic [11:0] EA = 12'h010;
    localparam logic [11:0] SU = 12'h008;
    localparam logic [11:0] EU = 12'h004;
    localparam logic [11:0] LB = 12'h002;
    localparam logic [11:0] LO = 12'h001;

`ifdef SAP1_VAR_CYCLE_EN
    localparam bit VAR_CYCLE = 1'b1;
`else
    localparam bit VAR_CYCLE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   op_defined;

    assign op_defined = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                        (opcode == OP_OUT) || (opcode == OP_HLT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_T1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run) begin
            case (state_q)
                S_T1:    state_d = S_T2;
                S_T2:    state_d = S_T3;
                S_T3:    state_d = (VAR_CYCLE && !op_defined) ? S_T1 : S_T4;
                S_T4: begin
                    if (opcode == OP_HLT)
                        state_d = S_HALT;
                    else if (VAR_CYCLE && (opcode == OP_OUT))
                        state_d = S_T1;
                    else
                        state_d = S_T5;
                end
                S_T5:    state_d = (VAR_CYCLE && (opcode == OP_LDA)) ? S_T1 : S_T6;
                S_T6:    state_d = S_T1;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_T1;
            endcase
        end
    end

    always_comb begin
        con = '0;
        case (state_q)
            S_T1: con = EP | LM;
            S_T2: con = CP;
            S_T3: con = ER | LI;
            S_T4: begin
                if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB))
                    con = EI | LM;
                else if (opcode == OP_OUT)
                    con = EA | LO;
            end
            S_T5: begin
                if (opcode == OP_LDA)
                    con = ER | LA;
                else if ((opcode == OP_ADD) || (opcode == OP_SUB))
                    con = ER | LB;
            end
            S_T6: begin
                if (opcode == OP_ADD)
                    con = LA | EU;
                else if (opcode == OP_SUB)
                    con = LA | SU | EU;
            end
            default: con = '0;
        endcase
        // Reset and a frozen ring must never leak a strobe to the falling-edge datapath.
        if (!reset || !run)
            con = '0;
    end

    always_comb begin
        t_state = 6'b000000;
        case (state_q)
            S_T1:    t_state = 6'b000001;
            S_T2:    t_state = 6'b000010;
            S_T3:    t_state = 6'b000100;
            S_T4:    t_state = 6'b001000;
            S_T5:    t_state = 6'b010000;
            S_T6:    t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

    assign halted = (state_q == S_HALT);

endmodule
